// File: rtl/coin_input_conditioner.sv
// coin_input_conditioner: synchronizes and debounces three raw coin buttons,
// turns each clean press into one coin event, and queues the events in a
// 4-deep FIFO that the vending controller drains through a valid/ack handshake.

// Per-button synchronizer, debouncer and press detector.
module coin_btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic clr,
    input  logic i_raw,
    output logic o_press
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_deb;
    logic             r_deb_d;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;

    // Two-flop synchronizer for the asynchronous button input.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce: the state flips only after the synced input has disagreed
    // with it for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_deb <= 1'b0;
            r_cnt <= '0;
        end else if (r_sync2 == r_deb) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_MAX) begin
            r_deb <= r_sync2;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Registered rising-edge detect of the debounced state; releases are ignored.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_deb_d <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_deb_d <= r_deb;
            r_press <= r_deb & ~r_deb_d;
        end
    end

    assign o_press = r_press;

endmodule

module coin_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [2:0] btn,
    input  logic       coin_ack,
    output logic       coin_valid,
    output logic [1:0] coin_code,
    output logic [4:0] coin_value,
    output logic       fifo_full,
    output logic       overflow
);

    localparam int NUM_BTN = 3;
    localparam int DEPTH   = 4;

    logic [NUM_BTN-1:0] w_press;
    logic [NUM_BTN-1:0] r_pend;
    logic               r_ovf;

    logic [1:0]         r_mem [DEPTH];
    logic [1:0]         r_wr;
    logic [1:0]         r_rd;
    logic [2:0]         r_cnt;

    logic               w_pop;
    logic               w_room;
    logic               w_xfer;
    logic [1:0]         w_xfer_code;
    logic [NUM_BTN-1:0] w_xfer_oh;

    // One conditioning lane per coin button.
    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        coin_btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_db (
            .clk     (clk),
            .clr     (clr),
            .i_raw   (btn[g]),
            .o_press (w_press[g])
        );
    end

    // A pop frees a slot in the same cycle, so a full FIFO can still accept.
    assign w_pop  = coin_ack & (r_cnt != 3'd0);
    assign w_room = (r_cnt != 3'(DEPTH)) | w_pop;

    // Pick the lowest-index pending button to move into the FIFO this cycle.
    always_comb begin
        w_xfer      = 1'b0;
        w_xfer_code = 2'd0;
        w_xfer_oh   = '0;
        if (w_room) begin
            if (r_pend[0]) begin
                w_xfer      = 1'b1;
                w_xfer_code = 2'd0;
                w_xfer_oh   = 3'b001;
            end else if (r_pend[1]) begin
                w_xfer      = 1'b1;
                w_xfer_code = 2'd1;
                w_xfer_oh   = 3'b010;
            end else if (r_pend[2]) begin
                w_xfer      = 1'b1;
                w_xfer_code = 2'd2;
                w_xfer_oh   = 3'b100;
            end
        end
    end

    // Pending flags hold one press per button; a press onto a set flag is lost.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_pend <= '0;
            r_ovf  <= 1'b0;
        end else begin
            r_pend <= (r_pend & ~w_xfer_oh) | (w_press & ~r_pend);
            r_ovf  <= r_ovf | (|(w_press & r_pend));
        end
    end

    // Circular FIFO storage and pointers; simultaneous push/pop keeps the count.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= 2'd0;
            r_wr  <= 2'd0;
            r_rd  <= 2'd0;
            r_cnt <= 3'd0;
        end else begin
            if (w_xfer) begin
                r_mem[r_wr] <= w_xfer_code;
                r_wr        <= r_wr + 2'd1;
            end
            if (w_pop) r_rd <= r_rd + 2'd1;
            case ({w_xfer, w_pop})
                2'b10:   r_cnt <= r_cnt + 3'd1;
                2'b01:   r_cnt <= r_cnt - 3'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Outputs decoded from registers only; head fields read as zero when empty.
    always_comb begin
        coin_valid = (r_cnt != 3'd0);
        fifo_full  = (r_cnt == 3'(DEPTH));
        overflow   = r_ovf;
        coin_code  = coin_valid ? r_mem[r_rd] : 2'd0;
        coin_value = 5'd0;
        if (coin_valid) begin
            case (coin_code)
                2'd0:    coin_value = 5'd5;
                2'd1:    coin_value = 5'd10;
                2'd2:    coin_value = 5'd25;
                default: coin_value = 5'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Bench for coin_input_conditioner: directed scenarios plus random button
// activity, checked against a cycle-level behavioural model and an event
// scoreboard that is drained by a monitor on every handshake.
module tb_coin_input_conditioner;

    localparam int DC = 4;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [2:0] btn = 3'b000;
    logic       coin_ack = 1'b0;
    logic       coin_valid;
    logic [1:0] coin_code;
    logic [4:0] coin_value;
    logic       fifo_full;
    logic       overflow;

    always #5 clk = ~clk;

    coin_input_conditioner #(.DEBOUNCE_CYCLES(DC), .CNT_W(3)) dut (
        .clk        (clk),
        .clr        (clr),
        .btn        (btn),
        .coin_ack   (coin_ack),
        .coin_valid (coin_valid),
        .coin_code  (coin_code),
        .coin_value (coin_value),
        .fifo_full  (fifo_full),
        .overflow   (overflow)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int val_of(input int c);
        case (c)
            0:       return 5;
            1:       return 10;
            2:       return 25;
            default: return 0;
        endcase
    endfunction

    // ---------------- behavioural model ----------------
    // hist keeps the raw button samples of the last DC+1 edges; the value the
    // debouncer sees at an edge is the raw sample from two edges earlier.
    logic [2:0] hist [$];
    logic [2:0] mdeb, pd0, pd1, mpend, m_old, m_rise, m_pressed, h;
    int         mq [$];
    int         exp_q [$];
    bit         movf, m_pop, m_all;
    int         m_x;
    int         seen [$];
    int         seenv [$];

    always @(posedge clk or negedge clr) begin
        if (!clr) begin
            hist.delete();
            for (int i = 0; i < DC + 1; i++) hist.push_back(3'b000);
            mdeb = 0; pd0 = 0; pd1 = 0; mpend = 0; movf = 0;
            mq.delete();
            exp_q.delete();
        end else begin
            // debounced state flips once DC consecutive seen samples disagree
            m_rise = 0;
            for (int b = 0; b < 3; b++) begin
                m_all = 1;
                for (int j = 0; j < DC; j++) begin
                    h = hist[hist.size() - 2 - j];
                    if (h[b] == mdeb[b]) m_all = 0;
                end
                if (m_all) begin
                    mdeb[b] = ~mdeb[b];
                    if (mdeb[b]) m_rise[b] = 1;
                end
            end
            hist.push_back(btn);
            if (hist.size() > DC + 1) void'(hist.pop_front());
            // a debounced rise reaches the pending flags two edges later
            m_pressed = pd1;
            pd1 = pd0;
            pd0 = m_rise;
            m_old = mpend;
            m_pop = coin_ack && (mq.size() > 0);
            m_x = -1;
            if (mq.size() < 4 || m_pop)
                for (int b = 0; b < 3; b++)
                    if (m_x < 0 && mpend[b]) m_x = b;
            if (m_pop) void'(mq.pop_front());
            if (m_x >= 0) begin
                mpend[m_x] = 0;
                mq.push_back(m_x);
                exp_q.push_back(m_x);
            end
            for (int b = 0; b < 3; b++)
                if (m_pressed[b]) begin
                    if (m_old[b]) movf = 1;
                    else mpend[b] = 1;
                end
        end
    end

    // ---------------- monitor ----------------
    int e;
    always @(negedge clk) begin
        if (clr) begin
            chk("valid", coin_valid, mq.size() != 0);
            chk("full", fifo_full, mq.size() == 4);
            chk("overflow", overflow, movf);
            if (!coin_valid) begin
                chk("empty_code", coin_code, 0);
                chk("empty_value", coin_value, 0);
            end
            if (coin_valid && coin_ack) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_unexpected: got code %0d, expected no event (t=%0t)", coin_code, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("pop_code", coin_code, e);
                    chk("pop_value", coin_value, val_of(e));
                end
                seen.push_back(int'(coin_code));
                seenv.push_back(int'(coin_value));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic press(input int b);
        btn[b] = 1'b1;
        cyc(6);
        btn[b] = 1'b0;
        cyc(8);
    endtask

    initial begin
        // reset with all buttons held
        #1 clr = 1'b0;
        btn = 3'b111;
        cyc(3);
        chk("rst_valid", coin_valid, 0);
        chk("rst_code", coin_code, 0);
        chk("rst_value", coin_value, 0);
        chk("rst_full", fifo_full, 0);
        chk("rst_overflow", overflow, 0);
        clr = 1'b1;
        coin_ack = 1'b1;
        seen.delete(); seenv.delete();
        cyc(25);
        chk("rst_held_events", seen.size(), 3);
        if (seen.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                chk("rst_held_code", seen[i], i);
                chk("rst_held_value", seenv[i], val_of(i));
            end
        end
        btn = 3'b000;
        cyc(15);
        chk("rst_release_events", seen.size(), 3);
        coin_ack = 1'b0;

        // single press latency
        seen.delete(); seenv.delete();
        btn[1] = 1'b1;
        cyc(8);
        @(negedge clk);
        chk("lat_before", coin_valid, 0);
        @(posedge clk);
        @(negedge clk);
        chk("lat_valid", coin_valid, 1);
        chk("lat_code", coin_code, 1);
        chk("lat_value", coin_value, 10);
        cyc(1);
        coin_ack = 1'b1;
        cyc(1);
        coin_ack = 1'b0;
        @(negedge clk);
        chk("ack_clears", coin_valid, 0);
        cyc(8);
        btn[1] = 1'b0;
        cyc(15);
        chk("single_events", seen.size(), 1);

        // bounce, then a short glitch
        coin_ack = 1'b1;
        seen.delete(); seenv.delete();
        for (int i = 0; i < 6; i++) begin
            btn[2] = ~btn[2];
            cyc(2);
        end
        btn[2] = 1'b1;
        cyc(20);
        chk("bounce_events", seen.size(), 1);
        if (seen.size() == 1) chk("bounce_value", seenv[0], 25);
        btn[2] = 1'b0;
        cyc(15);
        seen.delete(); seenv.delete();
        btn[0] = 1'b1;
        cyc(3);
        btn[0] = 1'b0;
        cyc(20);
        chk("glitch_events", seen.size(), 0);

        // fill, backpressure, overflow
        coin_ack = 1'b0;
        repeat (4) press(0);
        chk("full_after4", fifo_full, 1);
        press(0);
        chk("full_after5", fifo_full, 1);
        chk("ovf_after5", overflow, 0);
        press(0);
        chk("ovf_after6", overflow, 1);
        coin_ack = 1'b1;
        cyc(1);
        coin_ack = 1'b0;
        chk("full_after_ack", fifo_full, 1);
        coin_ack = 1'b1;
        cyc(8);
        coin_ack = 1'b0;
        chk("drained", coin_valid, 0);

        // push and pop in the same cycle on a full FIFO
        press(0); press(1); press(2); press(0);
        chk("pp_full", fifo_full, 1);
        press(1);
        seen.delete(); seenv.delete();
        coin_ack = 1'b1;
        cyc(1);
        coin_ack = 1'b0;
        chk("pp_still_full", fifo_full, 1);
        chk("pp_head", coin_code, 1);
        if (seen.size() == 1) chk("pp_popped", seen[0], 0);
        else chk("pp_pop_count", seen.size(), 1);
        coin_ack = 1'b1;
        cyc(8);
        coin_ack = 1'b0;

        // asynchronous reset mid-operation
        press(0); press(1); press(2);
        chk("mid_queued", coin_valid, 1);
        clr = 1'b0;
        #1;
        chk("mid_rst_valid", coin_valid, 0);
        chk("mid_rst_code", coin_code, 0);
        chk("mid_rst_value", coin_value, 0);
        chk("mid_rst_full", fifo_full, 0);
        chk("mid_rst_ovf", overflow, 0);
        #1 clr = 1'b1;
        seen.delete(); seenv.delete();
        coin_ack = 1'b1;
        cyc(20);
        chk("mid_no_stale", seen.size(), 0);

        // random activity with a reset in the middle
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 3; b++)
                if ($urandom_range(0, 5) == 0) btn[b] = ~btn[b];
            coin_ack = ($urandom_range(0, 3) == 0);
            if (c == 1500) begin
                clr = 1'b0;
                #1 clr = 1'b1;
            end
            cyc(1);
        end
        btn = 3'b000;
        coin_ack = 1'b1;
        cyc(40);
        chk("final_scoreboard_empty", exp_q.size(), 0);
        chk("final_valid", coin_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/coin_input_conditioner.md
# coin_input_conditioner

Front end between the raw coin push-buttons and the vending-machine controller. It synchronizes and debounces three coin buttons and converts each clean press into exactly one coin event. Events are queued in a small FIFO and presented to the controller through a valid/ack handshake, so no coin is lost when the controller only acts on its slow 1 Hz enable. The controller is the consumer of this block's coin-event interface.

## Interface
- DEBOUNCE_CYCLES, 1_000_000: consecutive clk cycles a synchronized input must differ from its debounced state before the state flips (10 ms at 100 MHz); must be >= 2.
- CNT_W, 20: debounce counter width; must hold DEBOUNCE_CYCLES-1.
- clk  input  1  system clock; the block's only clock.
- clr  input  1  reset; asynchronous, active-low.
- btn  input  3  raw, asynchronous coin buttons, active-high; btn[0]=5c, btn[1]=10c, btn[2]=25c.
- coin_ack  input  1  consumer pops the head event; honoured only while coin_valid=1.
- coin_valid  output  1  FIFO non-empty; head event presented.
- coin_code  output  2  head event button index (0..2); 0 when empty.
- coin_value  output  5  head event value in cents (5, 10, 25); 0 when empty.
- fifo_full  output  1  FIFO holds 4 events.
- overflow  output  1  sticky: at least one press was dropped since reset.

## Operation
- Per button: 2-flop synchronizer, then debounce. The counter clears whenever sync equals the debounced state. It increments while they differ. When it reaches DEBOUNCE_CYCLES-1 and they still differ, the debounced state takes the sync value and the counter clears.
- A 0->1 transition of a debounced state is a press. Releases generate nothing.
- Press sets that button's pending flag. If the flag is already set, the press is dropped and overflow sets.
- Each cycle at most one pending flag is transferred to the FIFO: the lowest index wins, and the flag clears on transfer. Transfer is allowed when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
- FIFO: 4 entries of 2-bit code, circular read/write pointers plus a 3-bit count. Push and pop in the same cycle leave the count unchanged. coin_ack while coin_valid=0 is ignored and does not underflow.
- coin_value is decoded from the head code: 0->5, 1->10, 2->25. Code 3 never occurs.
- Reset, asynchronous and active-low, may occur mid-operation. It clears synchronizers, debounced states (released), counters, pending flags, FIFO pointers/count and overflow. Queued events are discarded.
- Reset values: coin_valid=0, coin_code=0, coin_value=0, fifo_full=0, overflow=0.
- A button held through reset release produces one press after the debounce time.

## Timing
- Synchronizer: 2 cycles. Debounce: DEBOUNCE_CYCLES cycles. Pending flag: 1 cycle. FIFO write: 1 cycle.
- Latency: with an idle FIFO, a raw rise first sampled at edge k gives coin_valid=1 after edge k+DEBOUNCE_CYCLES+4.
- All outputs are registered or decoded from registers only; no combinational path from btn or coin_ack to any output.
- Pop: coin_ack=1 with coin_valid=1 at edge k advances the head at edge k. The next event, or coin_valid=0, is visible after edge k.
- Simultaneous presses on all three buttons enter the FIFO on consecutive cycles in order 0, 1, 2.
- Glitches: bounces shorter than DEBOUNCE_CYCLES produce no event.
- overflow stays high until reset.

## Test plan
Simulation uses DEBOUNCE_CYCLES=4.
- Reset: clr low with btn=3'b111 -> all outputs 0. After release with btn held, exactly three events appear: codes 0, 1, 2 with values 5, 10, 25.
- Single press: btn[1] rises, held 20 cycles -> coin_valid rises exactly 8 cycles after the first sampling edge, with coin_code=1 and coin_value=10. A 1-cycle coin_ack -> coin_valid=0 the next cycle, and no second event on release.
- Bounce: btn[2] toggles every 2 cycles for 12 cycles, then stays high -> exactly one event with coin_value=25. A 3-cycle pulse on btn[0] -> no event.
- Full/backpressure: 5 separated btn[0] presses, no ack -> fifo_full=1 after the 4th; the 5th stays pending and overflow stays 0. A 6th press -> overflow=1. One ack -> the pending event enters in the same cycle, and fifo_full stays 1.
- Simultaneous push/pop: FIFO full, coin_ack in the same cycle a pending event transfers -> count stays 4, and the head advances to the correct next code.
- Mid-operation reset: 3 events queued, clr pulsed low for 1 cycle between clock edges -> outputs 0 immediately, and no stale events afterward.
